// File: rtl/stream_conv3x3.sv
// Streaming 3x3 convolution (passthrough / Gaussian / Sobel-X / Sobel-Y) over raster-order frames.
// Define STREAM_CONV3X3_SOBEL_MAG_EN for a 3-bit mode with mode 4 = saturated |Gx|+|Gy|.
module stream_conv3x3 #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef STREAM_CONV3X3_SOBEL_MAG_EN
  input  logic [2:0]       mode,
`else
  input  logic [1:0]       mode,
`endif
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_last
);

`ifdef STREAM_CONV3X3_SOBEL_MAG_EN
  localparam int MODE_W = 3;
`else
  localparam int MODE_W = 2;
`endif
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = PIX_W + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [MODE_W-1:0] M_GAUSS = MODE_W'(1);
  localparam logic [MODE_W-1:0] M_SOBX  = MODE_W'(2);
  localparam logic [MODE_W-1:0] M_SOBY  = MODE_W'(3);
`ifdef STREAM_CONV3X3_SOBEL_MAG_EN
  localparam logic [MODE_W-1:0] M_MAG   = MODE_W'(4);
`endif

  // Valid/ready: a beat moves on a port only in a cycle where valid and ready are both
  // high; m_valid never depends on m_ready, s_ready is the stage-1 advance condition.
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [MODE_W-1:0]   r_mode;
  logic [PIX_W-1:0]    r_lb0 [IMG_W];
  logic [PIX_W-1:0]    r_lb1 [IMG_W];
  logic [PIX_W-1:0]    r_win [3][2];
  logic [PIX_W-1:0]    w_col_new [3];
  logic [PIX_W+1:0]    w_gr [3];
  logic signed [PIX_W:0] w_dx [3];
  logic                w_acc, w_adv1, w_adv2, w_out_pos;

  logic                r_s1_valid, r_s1_last;
  logic [MODE_W-1:0]   r_s1_mode;
  logic [PIX_W+1:0]    r_s1_gr [3];
  logic signed [PIX_W:0] r_s1_dx [3];
  logic [PIX_W-1:0]    r_s1_ctr;

  logic                r_m_valid, r_m_last;
  logic [PIX_W-1:0]    r_m_data;
  logic [SW-1:0]       w_gauss_sum;
  logic signed [SW-1:0] w_dxe [3];
  logic signed [SW-1:0] w_gx, w_gy;
  logic [SW-1:0]       w_ax, w_ay;
`ifdef STREAM_CONV3X3_SOBEL_MAG_EN
  logic [SW-1:0]       w_mag;
`endif
  logic [PIX_W-1:0]    w_result;

  assign w_adv2    = !r_m_valid || m_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign s_ready   = w_adv1 && !reset;
  assign w_acc     = s_valid && s_ready;
  assign w_out_pos = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;

  function automatic logic [PIX_W-1:0] f_sat(input logic [SW-1:0] v);
    if (|v[SW-1:PIX_W]) return {PIX_W{1'b1}};
    return v[PIX_W-1:0];
  endfunction

  // r_win keeps the left and centre columns; the right column arrives from the line
  // buffers and s_data, so stage 1 sees the window ending at the pixel being accepted.
  always_comb begin
    w_col_new[0] = r_lb1[r_col];
    w_col_new[1] = r_lb0[r_col];
    w_col_new[2] = s_data;
    for (int i = 0; i < 3; i++) begin
      w_gr[i] = {2'b00, r_win[i][0]} + {1'b0, r_win[i][1], 1'b0} + {2'b00, w_col_new[i]};
      w_dx[i] = $signed({1'b0, w_col_new[i]}) - $signed({1'b0, r_win[i][0]});
    end
  end

  always_comb begin
    w_gauss_sum = {2'b00, r_s1_gr[0]} + {1'b0, r_s1_gr[1], 1'b0} + {2'b00, r_s1_gr[2]};
    for (int i = 0; i < 3; i++) w_dxe[i] = {{3{r_s1_dx[i][PIX_W]}}, r_s1_dx[i]};
    w_gx = w_dxe[0] + w_dxe[1] + w_dxe[1] + w_dxe[2];
    w_gy = $signed({2'b00, r_s1_gr[2]}) - $signed({2'b00, r_s1_gr[0]});
    w_ax = w_gx[SW-1] ? -w_gx : w_gx;
    w_ay = w_gy[SW-1] ? -w_gy : w_gy;
`ifdef STREAM_CONV3X3_SOBEL_MAG_EN
    w_mag = w_ax + w_ay;
`endif
    case (r_s1_mode)
      M_GAUSS: w_result = PIX_W'(w_gauss_sum >> 4);
      M_SOBX:  w_result = f_sat(w_ax);
      M_SOBY:  w_result = f_sat(w_ay);
`ifdef STREAM_CONV3X3_SOBEL_MAG_EN
      M_MAG:   w_result = f_sat(w_mag);
`endif
      default: w_result = r_s1_ctr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_mode     <= '0;
      r_s1_valid <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_data   <= '0;
    end else begin
      if (w_acc) begin
        if (r_col == '0 && r_row == '0) r_mode <= mode;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_adv1) r_s1_valid <= w_acc && w_out_pos;
      if (w_adv2) begin
        r_m_valid <= r_s1_valid;
        r_m_last  <= r_s1_valid && r_s1_last;
        if (r_s1_valid) r_m_data <= w_result;
      end
    end
  end

  // Storage only; a reset leaves stale pixels here that never reach an output window.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[r_col] <= s_data;
      r_lb1[r_col] <= r_lb0[r_col];
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= w_col_new[i];
      end
      if (w_out_pos) begin
        for (int i = 0; i < 3; i++) begin
          r_s1_gr[i] <= w_gr[i];
          r_s1_dx[i] <= w_dx[i];
        end
        r_s1_ctr  <= r_win[1][1];
        r_s1_mode <= r_mode;
        r_s1_last <= (r_row == ROW_LAST) && (r_col == COL_LAST);
      end
    end
  end

endmodule

// File: tb/tb_stream_conv3x3.sv
// Bench for stream_conv3x3: random and directed frames scored against a plain-arithmetic
// 3x3 convolution model; honours STREAM_CONV3X3_SOBEL_MAG_EN for the magnitude mode.
module tb_stream_conv3x3;
  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);
  localparam int MAXV  = (1 << PIX_W) - 1;
`ifdef STREAM_CONV3X3_SOBEL_MAG_EN
  localparam int MODE_W = 3;
`else
  localparam int MODE_W = 2;
`endif
  localparam int MODE_MAX = (1 << MODE_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [MODE_W-1:0] mode = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [PIX_W-1:0]  s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [PIX_W-1:0]  m_data;
  logic              m_last;

  stream_conv3x3 #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [PIX_W:0] exp_q[$];
  int img [IMG_H][IMG_W];
  int kg [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
  bit stall_force = 0, rdy_rand = 0, gap_en = 0, saw_sready_low = 0, hold = 0;
  logic [PIX_W-1:0] hold_data;
  logic hold_last;
  int n_out = 0, n_last = 0, base_out = 0, base_last = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int sat_abs(input int v);
    if (v < 0) v = -v;
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic int ref_pix(input int m, input int r, input int c);
    int sg = 0, sx = 0, sy = 0, p;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        p = img[r-2+i][c-2+j];
        sg += kg[i][j] * p;
        sx += kx[i][j] * p;
        sy += ky[i][j] * p;
      end
    case (m)
      1: return sg / 16;
      2: return sat_abs(sx);
      3: return sat_abs(sy);
`ifdef STREAM_CONV3X3_SOBEL_MAG_EN
      4: return sat_abs((sx < 0 ? -sx : sx) + (sy < 0 ? -sy : sy));
`endif
      default: return img[r-1][c-1];
    endcase
  endfunction

  // driver tasks
  initial forever begin
    @(posedge clk); #1;
    if (stall_force) m_ready = 1'b0;
    else if (rdy_rand) m_ready = ($urandom_range(0, 2) != 0);
    else m_ready = 1'b1;
  end

  task automatic send_pixel(input int d);
    int t = 0;
    bit acc = 0;
    if (gap_en)
      while ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    s_valid = 1'b1;
    s_data  = PIX_W'(d);
    while (!acc && t < 1000) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0;
    check("accept", acc, 1);
  endtask

  // pat: 0 constant val, 1 10*col, 2 255 at col>=4, 3 10*(col+row), 4 random, 5 reuse image
  task automatic send_frame(input int m, input int pat, input int val, input bit scramble);
    base_out  = n_out;
    base_last = n_last;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        case (pat)
          0: img[r][c] = val;
          1: img[r][c] = 10 * c;
          2: img[r][c] = (c >= 4) ? 255 : 0;
          3: img[r][c] = 10 * c + 10 * r;
          4: img[r][c] = $urandom_range(0, MAXV);
          default: ;
        endcase
    for (int r = 2; r < IMG_H; r++)
      for (int c = 2; c < IMG_W; c++)
        exp_q.push_back({((r == IMG_H - 1) && (c == IMG_W - 1)), PIX_W'(ref_pix(m, r, c))});
    mode = MODE_W'(m);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        send_pixel(img[r][c]);
        if (scramble) mode = MODE_W'($urandom_range(0, MODE_MAX));
      end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    check("frame_outputs", n_out - base_out, NOUT);
    check("frame_lasts", n_last - base_last, 1);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [PIX_W:0] e;
    if (reset) begin
      hold = 0;
    end else begin
      if (hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hold_data);
        check("hold_last", m_last, hold_last);
      end
      if (stall_force && !s_ready) saw_sready_low = 1;
      if (m_valid && m_ready) begin
        n_out++;
        if (m_last) n_last++;
        check("out_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", m_data, e[PIX_W-1:0]);
          check("out_last", m_last, e[PIX_W]);
        end
      end
      hold      = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_m_valid", m_valid, 0);
    @(posedge clk); #1;

    send_frame(1, 0, 100, 0); wait_drain();
    send_frame(2, 1, 0, 0);   wait_drain();
    send_frame(3, 1, 0, 0);   wait_drain();
    send_frame(2, 2, 0, 0);   wait_drain();
    send_frame(0, 4, 0, 0);   wait_drain();

    // same image without and then with a 5-cycle downstream stall
    send_frame(1, 4, 0, 0);   wait_drain();
    saw_sready_low = 0;
    fork
      send_frame(1, 5, 0, 0);
      begin
        repeat (22) @(posedge clk);
        stall_force = 1;
        repeat (5) @(posedge clk);
        stall_force = 0;
      end
    join
    wait_drain();
    check("stall_sready_low", saw_sready_low, 1);

    send_frame(2, 4, 0, 1);   wait_drain();
`ifdef STREAM_CONV3X3_SOBEL_MAG_EN
    send_frame(4, 3, 0, 0);   wait_drain();
`endif

    rdy_rand = 1;
    gap_en   = 1;
    for (int f = 0; f < 6; f++) begin
      send_frame($urandom_range(0, MODE_MAX), 4, 0, 1);
      wait_drain();
    end
    rdy_rand = 0;
    gap_en   = 0;

    // aborted frame: 20 pixels with outputs blocked, then reset
    stall_force = 1;
    mode = MODE_W'($urandom_range(0, MODE_MAX));
    for (int i = 0; i < 20; i++) send_pixel($urandom_range(0, MAXV));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    stall_force = 0;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready_up", s_ready, 1);
    @(posedge clk); #1;
    send_frame(1, 0, 50, 0);  wait_drain();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_conv3x3.md
STREAM_CONV3X3 -- requirements
Module: stream_conv3x3

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 8, meaning pixels per line (minimum 3).
REQ-003 The block SHALL have parameter IMG_H, default 8, meaning lines per frame (minimum 3).
REQ-004 The block SHALL have port clk, input, 1 bit, the clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port mode, input, 2 bits: 0 passthrough, 1 Gaussian, 2 Sobel-X, 3 Sobel-Y.
REQ-007 The block SHALL have port s_valid, input, 1 bit, input pixel valid.
REQ-008 The block SHALL have port s_ready, output, 1 bit, the block accepts the input pixel.
REQ-009 The block SHALL have port s_data, input, PIX_W bits, unsigned input pixel in raster order.
REQ-010 The block SHALL have port m_valid, output, 1 bit, output pixel valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit, downstream accepts the output pixel.
REQ-012 The block SHALL have port m_data, output, PIX_W bits, unsigned filtered pixel.
REQ-013 The block SHALL have port m_last, output, 1 bit, marking the final output pixel of a frame.

Function
REQ-014 A transfer SHALL occur on either port only in a cycle where both valid and ready are high; valid SHALL NOT depend on ready.
REQ-015 Column and row counters SHALL advance per accepted input pixel, wrap at IMG_W-1 and IMG_H-1, and return to (0,0) after the last pixel of a frame.
REQ-016 Two line buffers of IMG_W x PIX_W plus a 3x3 window register SHALL supply the window whose bottom-right pixel is the most recently accepted pixel.
REQ-017 An output SHALL be produced only for accepted input (r,c) with r>=2 and c>=2, giving exactly (IMG_W-2)*(IMG_H-2) outputs per frame with no border padding.
REQ-018 The Gaussian mode SHALL use kernel 1 2 1 / 2 4 2 / 1 2 1; the sum SHALL be shifted right by 4, truncating.
REQ-019 The Sobel-X mode SHALL use -1 0 1 / -2 0 2 / -1 0 1, and the Sobel-Y mode SHALL use -1 -2 -1 / 0 0 0 / 1 2 1; both SHALL compute at PIX_W+4 bits signed, and the output SHALL be the absolute value saturated to 2^PIX_W-1.
REQ-020 The passthrough mode SHALL output the window centre pixel.
REQ-021 mode SHALL be sampled on acceptance of pixel (0,0), held for the whole frame, and changes mid-frame SHALL be ignored.
REQ-022 The datapath SHALL be a two-stage pipeline (products/partial sums, then final sum/normalise); m_valid for an output SHALL rise two cycles after the corresponding input is accepted when m_ready is held high.
REQ-023 Each stage SHALL advance when the next stage is empty or being consumed, and s_ready SHALL equal that condition for stage 1.
REQ-024 With m_ready low, m_data and m_last SHALL stay stable while m_valid is high, and no data SHALL be lost or duplicated.
REQ-025 m_last SHALL be high with the output for input (IMG_H-1, IMG_W-1) and low otherwise.
REQ-026 Simultaneous input and output transfers in one cycle SHALL sustain one pixel per cycle throughput.

Reset
REQ-027 On reset, m_valid, m_last and m_data SHALL be 0, s_ready SHALL be 0 in the reset cycle and 1 in the following cycle, the counters SHALL return to (0,0), and the pipeline valid bits SHALL clear.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame, and the next accepted pixel SHALL be treated as (0,0); line buffer contents need not be cleared.

Configuration
REQ-029 With macro STREAM_CONV3X3_SOBEL_MAG_EN defined, the mode register SHALL be 3 bits wide and mode 4 SHALL output min(|Gx|+|Gy|, 2^PIX_W-1), while modes 5-7 SHALL act as passthrough.
REQ-030 Without STREAM_CONV3X3_SOBEL_MAG_EN, mode SHALL remain 2 bits, and no Gx/Gy combining adder SHALL be instantiated.

Verification
REQ-031 Defaults, mode 1, a constant 100 frame, and m_ready high -> 36 outputs all 100, m_last on the 36th only.
REQ-032 Mode 2 with pixel = 10*column -> all outputs 80; the same frame in mode 3 -> all outputs 0.
REQ-033 Mode 2 with pixel = 255 at column >= 4 and 0 elsewhere -> outputs at the edge saturate to 255, other outputs 0.
REQ-034 Stream a frame with m_ready low for 5 cycles mid-frame -> m_data held stable, s_ready drops, and the output sequence matches the no-stall run exactly.
REQ-035 Assert reset after 20 pixels, then send a full constant 50 frame in mode 1 -> exactly 36 outputs of 50, none from the aborted frame.
REQ-036 With STREAM_CONV3X3_SOBEL_MAG_EN, mode 4, pixel = 10*column + 10*row -> all outputs 160.
